target_hit_judge: RTL and testbench

Consumes the 0-9 target index from the game's random target generator and owns one round of play: light a target, wait for the player's button, judge hit/miss/timeout, then update score and lives. Closes the loop with the generator by supplying the score-derived modulus it divides by. Sits between the generator, the button inputs and the display/score logic.

---
 rtl/target_hit_judge.sv | 189 ++++++++++++++++++
 tb/tb_target_hit_judge.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : target_hit_judge
// Purpose  : Runs one round of the target game. It lights a target, judges a
//            hit, a miss or a timeout, and keeps the score and the lives.
//            Define NO_REPEAT_EN to stop the same target lighting twice in a row.
// Revision : 1.0
// ============================================================================
module target_hit_judge #(
  parameter int unsigned NUM_TARGETS    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES     = 5000000,
  parameter logic [31:0] HIT_POINTS     = 32'd1,
  parameter int unsigned LIVES          = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ranNumTen,
  input  logic [NUM_TARGETS-1:0] buttons,
  output logic [3:0]             target_idx,
  output logic [NUM_TARGETS-1:0] target_onehot,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic [31:0]            score,
  output logic [31:0]            score_rng,
  output logic [3:0]             lives_left,
  output logic                   game_over
);

  localparam int unsigned TMAX    = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPAWN  = 3'd1,
    S_ACTIVE = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [TIMER_W-1:0]     timer_q;
  logic [31:0]            score_q;
  logic [3:0]             lives_q;
  logic [3:0]             target_idx_q;
  logic [NUM_TARGETS-1:0] target_onehot_q;
  logic                   hit_q;
  logic                   miss_q;
  logic                   game_over_q;
  logic [NUM_TARGETS-1:0] sync1_q;
  logic [NUM_TARGETS-1:0] sync2_q;
  logic [NUM_TARGETS-1:0] prev_q;
`ifdef NO_REPEAT_EN
  logic                   prev_valid_q;
`endif

  logic [NUM_TARGETS-1:0] w_edge;
  logic                   w_wrong;
  logic                   w_right;
  logic [32:0]            w_score_sum;
  logic [31:0]            w_score_sat;
  logic [3:0]             w_clamped;
  logic [3:0]             target_idx_d;
  logic [NUM_TARGETS-1:0] target_onehot_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // The lit mask is zero outside ACTIVE, so these only matter while a target is lit
  assign w_edge  = sync2_q & ~prev_q;
  assign w_wrong = |(w_edge & ~target_onehot_q);
  assign w_right = |(w_edge & target_onehot_q);

  assign w_score_sum = {1'b0, score_q} + {1'b0, HIT_POINTS};
  assign w_score_sat = w_score_sum[32] ? 32'hFFFF_FFFF : w_score_sum[31:0];

  always_comb begin
    w_clamped = ranNumTen;
    if (5'(ranNumTen) >= 5'(NUM_TARGETS)) begin
      w_clamped = ranNumTen - 4'(NUM_TARGETS);
    end
    target_idx_d = w_clamped;
`ifdef NO_REPEAT_EN
    if (prev_valid_q && (w_clamped == target_idx_q)) begin
      target_idx_d = (w_clamped == 4'(NUM_TARGETS - 1)) ? 4'd0 : w_clamped + 4'd1;
    end
`endif
    target_onehot_d = NUM_TARGETS'(1) << target_idx_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      score_q         <= '0;
      lives_q         <= 4'(LIVES);
      target_idx_q    <= '0;
      target_onehot_q <= '0;
      hit_q           <= 1'b0;
      miss_q          <= 1'b0;
      game_over_q     <= 1'b0;
`ifdef NO_REPEAT_EN
      prev_valid_q    <= 1'b0;
`endif
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_SPAWN;
        end
        S_SPAWN: begin
          target_idx_q    <= target_idx_d;
          target_onehot_q <= target_onehot_d;
          timer_q         <= '0;
`ifdef NO_REPEAT_EN
          prev_valid_q    <= 1'b1;
`endif
          state_q         <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_wrong || w_right || (timer_q == TIMEOUT_LAST)) begin
            state_q         <= S_RESULT;
            target_onehot_q <= '0;
            timer_q         <= '0;
            // A wrong edge wins even when the target bit rises in the same cycle
            if (!w_wrong && w_right) begin
              hit_q   <= 1'b1;
              score_q <= w_score_sat;
            end else begin
              miss_q <= 1'b1;
              if (lives_q != 4'd0) lives_q <= lives_q - 4'd1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESULT: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            if (lives_q == 4'd0) begin
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= S_SPAWN;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_OVER: begin
          if (start) begin
            score_q     <= '0;
            lives_q     <= 4'(LIVES);
            game_over_q <= 1'b0;
`ifdef NO_REPEAT_EN
            prev_valid_q <= 1'b0;
`endif
            state_q     <= S_SPAWN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign target_idx    = target_idx_q;
  assign target_onehot = target_onehot_q;
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;
  assign score         = score_q;
  assign score_rng     = (score_q < 32'd16) ? 32'd16 : score_q;
  assign lives_left    = lives_q;
  assign game_over     = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_target_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_target_hit_judge
// Purpose  : Self-checking bench for target_hit_judge. It plays randomized
//            rounds and compares the DUT against a round-level game model.
// Revision : 1.0
// ============================================================================
module tb_target_hit_judge;

  localparam int NT  = 10;
  localparam int TO  = 20;
  localparam int GAP = 4;
  localparam int LV  = 3;

  localparam int K_HIT   = 0;
  localparam int K_WRONG = 1;
  localparam int K_BOTH  = 2;
  localparam int K_TMO   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    ranNumTen = 4'd0;
  logic [NT-1:0] buttons = '0;

  logic [3:0]    target_idx, target_idx2;
  logic [NT-1:0] target_onehot, target_onehot2;
  logic          hit_pulse, hit_pulse2, miss_pulse, miss_pulse2;
  logic [31:0]   score, score2, score_rng, score_rng2;
  logic [3:0]    lives_left, lives_left2;
  logic          game_over, game_over2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_score, m_score2;
  int          m_lives;
  bit          m_prev_valid;
  int          m_prev;
  int          exp_lit;
  int          last_judge;
  int          last_idx;

  target_hit_judge #(
    .NUM_TARGETS(NT), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP),
    .HIT_POINTS(32'd1), .LIVES(LV)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ranNumTen(ranNumTen), .buttons(buttons),
    .target_idx(target_idx), .target_onehot(target_onehot), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .score(score), .score_rng(score_rng),
    .lives_left(lives_left), .game_over(game_over)
  );

  // Same stimulus, but a single hit drives the score straight to saturation
  target_hit_judge #(
    .NUM_TARGETS(NT), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP),
    .HIT_POINTS(32'hFFFF_FFFF), .LIVES(LV)
  ) dut_sat (
    .clock(clock), .reset(reset), .start(start), .ranNumTen(ranNumTen), .buttons(buttons),
    .target_idx(target_idx2), .target_onehot(target_onehot2), .hit_pulse(hit_pulse2),
    .miss_pulse(miss_pulse2), .score(score2), .score_rng(score_rng2),
    .lives_left(lives_left2), .game_over(game_over2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    if (a > (32'hFFFF_FFFF - b)) return 32'hFFFF_FFFF;
    return a + b;
  endfunction

  function automatic logic [31:0] rng_of(input logic [31:0] s);
    return (s < 32'd16) ? 32'd16 : s;
  endfunction

  task automatic model_reset();
    m_score = 32'd0; m_score2 = 32'd0; m_lives = LV; m_prev_valid = 1'b0; m_prev = 0;
  endtask

  task automatic play_round(input logic [3:0] ran, input int kind, input int d, input bit do_start);
    int idx, w, p, judge;
    logic [NT-1:0] mask, exp_oh;
    bit lit_ok, bad, exp_hit;
    @(negedge clock);
    ranNumTen = ran;
    if (do_start) begin
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      model_reset();
      exp_lit = cyc + 1;
      checks++;
      if (game_over !== 1'b0 || score !== 32'd0 || lives_left !== 4'(LV)) begin
        errors++;
        $display("FAIL start_clear: over=%0b score=%0h lives=%0d, required 0/0/%0d",
                 game_over, score, lives_left, LV);
      end
    end
    idx = int'(ran);
    if (idx >= NT) idx -= NT;
`ifdef NO_REPEAT_EN
    if (m_prev_valid && idx == m_prev) idx = (idx + 1) % NT;
`endif
    m_prev_valid = 1'b1;
    m_prev = idx;
    exp_oh = '0;
    exp_oh[idx] = 1'b1;

    lit_ok = 1'b0;
    for (int k = 0; k < 64 && !lit_ok; k++) begin
      @(posedge clock); #1;
      if (target_onehot !== '0) lit_ok = 1'b1;
    end
    checks++;
    if (!lit_ok || cyc != exp_lit) begin
      errors++;
      $display("FAIL lit_time: lit=%0b at cycle %0d, required cycle %0d", lit_ok, cyc, exp_lit);
    end
    if (!lit_ok) return;
    last_idx = int'(target_idx);
    checks++;
    if (target_idx !== 4'(idx) || target_onehot !== exp_oh) begin
      errors++;
      $display("FAIL target: idx=%0d onehot=%h, required idx=%0d onehot=%h",
               target_idx, target_onehot, idx, exp_oh);
    end
    checks++;
    if (score !== m_score || lives_left !== 4'(m_lives) || game_over !== 1'b0) begin
      errors++;
      $display("FAIL round_entry: score=%0h lives=%0d over=%0b, required %0h/%0d/0",
               score, lives_left, game_over, m_score, m_lives);
    end

    bad = 1'b0;
    if (kind == K_TMO) begin
      judge = cyc + TO;
      while (cyc < judge) begin
        @(posedge clock); #1;
        if (cyc < judge && (hit_pulse || miss_pulse || target_onehot !== exp_oh)) bad = 1'b1;
      end
    end else begin
      w = (idx + 1 + int'($urandom_range(0, NT - 2))) % NT;
      mask = '0;
      if (kind != K_WRONG) mask[idx] = 1'b1;
      if (kind != K_HIT) mask[w] = 1'b1;
      repeat (d) @(posedge clock);
      @(negedge clock);
      buttons = mask;
      start = 1'b1;
      p = cyc;
      judge = p + 3;
      while (cyc < judge) begin
        @(posedge clock); #1;
        start = 1'b0;
        if (cyc == p + 2) buttons = '0;
        if (cyc < judge && (hit_pulse || miss_pulse)) bad = 1'b1;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL early_pulse: pulse or target change before judgement cycle %0d, required none", judge);
    end

    exp_hit = (kind == K_HIT);
    if (exp_hit) begin
      m_score  = sat_add(m_score, 32'd1);
      m_score2 = sat_add(m_score2, 32'hFFFF_FFFF);
    end else begin
      m_lives--;
    end
    last_judge = judge;
    checks++;
    if (hit_pulse !== exp_hit || miss_pulse !== !exp_hit || target_onehot !== '0) begin
      errors++;
      $display("FAIL judge_pulse: hit=%0b miss=%0b onehot=%h, required hit=%0b miss=%0b onehot=0",
               hit_pulse, miss_pulse, target_onehot, exp_hit, !exp_hit);
    end
    checks++;
    if (score !== m_score || score_rng !== rng_of(m_score) || lives_left !== 4'(m_lives)) begin
      errors++;
      $display("FAIL judge_state: score=%0h rng=%0h lives=%0d, required %0h/%0h/%0d",
               score, score_rng, lives_left, m_score, rng_of(m_score), m_lives);
    end
    checks++;
    if (score2 !== m_score2 || score_rng2 !== rng_of(m_score2)) begin
      errors++;
      $display("FAIL sat_score: score=%0h rng=%0h, required %0h/%0h",
               score2, score_rng2, m_score2, rng_of(m_score2));
    end
    @(posedge clock); #1;
    checks++;
    if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: hit=%0b miss=%0b one cycle after judgement, required 0/0",
               hit_pulse, miss_pulse);
    end
    buttons = '0;
    exp_lit = judge + GAP + 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (target_onehot !== '0 || target_idx !== 4'd0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: onehot=%h idx=%0d hit=%0b miss=%0b, required all 0",
               target_onehot, target_idx, hit_pulse, miss_pulse);
    end
    checks++;
    if (score !== 32'd0 || score_rng !== 32'd16 || lives_left !== 4'(LV) || game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: score=%0h rng=%0h lives=%0d over=%0b, required 0/10/%0d/0",
               score, score_rng, lives_left, game_over, LV);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_mid();
    bit lit_ok, bad;
    play_round(4'd2, K_HIT, 1, 1'b1);
    @(negedge clock);
    ranNumTen = 4'd7;
    lit_ok = 1'b0;
    for (int k = 0; k < 64 && !lit_ok; k++) begin
      @(posedge clock); #1;
      if (target_onehot !== '0) lit_ok = 1'b1;
    end
    checks++;
    if (target_onehot !== 10'h080 || score !== 32'd1) begin
      errors++;
      $display("FAIL pre_reset: onehot=%h score=%0h, required 080/1", target_onehot, score);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (target_onehot !== '0 || score !== 32'd0 || lives_left !== 4'(LV) ||
        hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || target_idx !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: onehot=%h score=%0h lives=%0d hit=%0b miss=%0b idx=%0d, required 0/0/%0d/0/0/0",
               target_onehot, score, lives_left, hit_pulse, miss_pulse, target_idx, LV);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    bad = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (target_onehot !== '0 || hit_pulse || miss_pulse || game_over) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_after_reset: activity seen without start, required dark and silent");
    end
  endtask

  task automatic test_hit();
    play_round(4'd4, K_HIT, 0, 1'b1);
    checks++;
    if (score !== 32'd1) begin
      errors++;
      $display("FAIL hit_score: score=%0h, required 1", score);
    end
  endtask

  task automatic test_both_edges();
    play_round(4'd13, K_BOTH, int'($urandom_range(0, 8)), 1'b0);
    checks++;
    if (last_idx != 3 || lives_left !== 4'd2 || score !== 32'd1) begin
      errors++;
      $display("FAIL both_edges: idx=%0d lives=%0d score=%0h, required 3/2/1",
               last_idx, lives_left, score);
    end
  endtask

  task automatic test_random_to_40();
    int kind;
    int guard = 0;
    while (m_score < 32'd40 && guard < 80) begin
      kind = (m_lives > 1 && $urandom_range(0, 9) == 0) ? K_WRONG : K_HIT;
      play_round(4'($urandom_range(0, 15)), kind, int'($urandom_range(0, 10)), 1'b0);
      guard++;
    end
    checks++;
    if (score !== 32'd40 || score_rng !== 32'd40) begin
      errors++;
      $display("FAIL score_40: score=%0d rng=%0d, required 40/40", score, score_rng);
    end
  endtask

  task automatic test_timeout_over();
    bit bad;
    while (m_lives > 0) play_round(4'd9, K_TMO, 0, 1'b0);
    bad = 1'b0;
    while (cyc < last_judge + GAP) begin
      @(posedge clock); #1;
      if (cyc < last_judge + GAP && game_over !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || game_over !== 1'b1 || lives_left !== 4'd0 || score !== m_score || target_onehot !== '0) begin
      errors++;
      $display("FAIL game_over: early=%0b over=%0b lives=%0d score=%0h onehot=%h, required 0/1/0/%0h/0",
               bad, game_over, lives_left, score, target_onehot, m_score);
    end
    buttons = '1;
    bad = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (hit_pulse || miss_pulse || target_onehot !== '0 || !game_over || score !== m_score) bad = 1'b1;
    end
    buttons = '0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL over_hold: buttons in OVER changed outputs, required no change");
    end
  endtask

  task automatic test_restart_repeat();
    play_round(4'd9, K_HIT, 2, 1'b1);
    checks++;
    if (last_idx != 9 || lives_left !== 4'(LV) || score2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL restart: idx=%0d lives=%0d sat_score=%0h, required 9/%0d/ffffffff",
               last_idx, lives_left, score2, LV);
    end
    play_round(4'd9, K_HIT, 0, 1'b0);
    checks++;
`ifdef NO_REPEAT_EN
    if (last_idx != 0) begin
      errors++;
      $display("FAIL repeat_idx: idx=%0d, required 0", last_idx);
    end
`else
    if (last_idx != 9) begin
      errors++;
      $display("FAIL repeat_idx: idx=%0d, required 9", last_idx);
    end
`endif
  endtask

  initial begin
    model_reset();
    exp_lit = 0;
    last_judge = 0;
    last_idx = 0;
    test_reset();
    test_reset_mid();
    test_hit();
    test_both_edges();
    test_random_to_40();
    test_timeout_over();
    test_restart_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
